// File: rtl/eightbit_palu_ctrl_pkg.sv
// Shared types for the eightbit_palu_ctrl slice.
//   op_t        command opcodes (6 and 7 are illegal and have no member)
//   alu_sel_t   select encodings understood by the external eightbit_palu
//   state_t     controller FSM state, also exported on the debug port
//   sel_for()   maps an opcode onto the ALU select used while it executes
package eightbit_palu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_NOT  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_CLRF = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        SEL_ADD  = 2'd0,
        SEL_NOTB = 2'd1,
        SEL_AND  = 2'd2,
        SEL_OR   = 2'd3
    } alu_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // LOAD, CLRF and illegal opcodes never use the ALU result, so they
    // park the select at the ADD encoding.
    function automatic logic [1:0] sel_for(input logic [2:0] op);
        case (op)
            OP_ADD:  return SEL_ADD;
            OP_NOT:  return SEL_NOTB;
            OP_AND:  return SEL_AND;
            OP_OR:   return SEL_OR;
            default: return SEL_ADD;
        endcase
    endfunction

endpackage

// File: rtl/eightbit_palu_ctrl_if.sv
// Command/response bus of eightbit_palu_ctrl.
//   cmd_valid/cmd_ready, cmd_op[2:0], cmd_data[7:0], cmd_rep[3:0]
//   rsp_valid/rsp_ready, rsp_data[7:0], rsp_ovf, rsp_err
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The sender holds its payload stable while valid=1 and ready=0,
// and valid does not depend combinationally on ready.
// Modports: master = command producer / response consumer,
//           slave  = the controller.
interface eightbit_palu_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_rep;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_ovf;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_rep, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_rep, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
    );

endinterface

// File: rtl/eightbit_palu.sv
// External 8-bit combinational ALU driven by eightbit_palu_ctrl.
//   a, b  operands
//   sel   0 a+b, 1 ~b, 2 a&b, 3 a|b
//   f     result
//   ovf   carry-out of the addition, 0 for the other selects
module eightbit_palu
    import eightbit_palu_ctrl_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] sel,
    output logic [7:0] f,
    output logic       ovf
);

    logic [8:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        f   = 8'h00;
        ovf = 1'b0;
        case (sel)
            SEL_ADD:  begin f = sum[7:0]; ovf = sum[8]; end
            SEL_NOTB: f = ~b;
            SEL_AND:  f = a & b;
            SEL_OR:   f = a | b;
            default:  f = 8'h00;
        endcase
    end

endmodule

// File: rtl/eightbit_palu_ctrl.sv
// Accumulator controller in front of an external 8-bit ALU.
// A command is taken in IDLE, executed for one cycle (or rep+1 cycles for
// ADD) in EXEC while the accumulator is fed through the ALU, and the
// resulting accumulator is offered in RESP until the consumer takes it.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          command/response interface (slave side)
//   alu_sel/a/b  select and operands driven to the ALU
//   alu_f/ovf    ALU result and carry-out
//   acc_ovf      sticky carry flag, cleared by CLRF
//   dbg_state    current FSM state
module eightbit_palu_ctrl
    import eightbit_palu_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    eightbit_palu_ctrl_if.slave  bus,
    output logic [1:0]           alu_sel,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic [7:0]           alu_f,
    input  logic                 alu_ovf,
    output logic                 acc_ovf,
    output state_t               dbg_state
);

    state_t     state;
    logic [7:0] acc;
    logic [7:0] operand;
    logic [2:0] op_q;
    logic [3:0] cnt;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_ovf;
    logic       rsp_err;

    assign alu_a         = acc;
    assign alu_b         = operand;
    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = acc;
    assign bus.rsp_ovf   = rsp_ovf;
    assign bus.rsp_err   = rsp_err;
    assign dbg_state     = state;

    // cmd_ready, rsp_valid and alu_sel are registered alongside the state so
    // that they always agree with it: the select is loaded on acceptance and
    // parked back at 0 on the final EXEC edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= 8'h00;
            operand   <= 8'h00;
            op_q      <= 3'd0;
            cnt       <= 4'd0;
            acc_ovf   <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b0;
            alu_sel   <= SEL_ADD;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q      <= bus.cmd_op;
                        operand   <= bus.cmd_data;
                        // Only ADD repeats; everything else runs once.
                        cnt       <= (bus.cmd_op == OP_ADD) ? bus.cmd_rep : 4'd0;
                        rsp_ovf   <= 1'b0;
                        rsp_err   <= 1'b0;
                        alu_sel   <= sel_for(bus.cmd_op);
                        cmd_ready <= 1'b0;
                        state     <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            acc     <= alu_f;
                            rsp_ovf <= rsp_ovf | alu_ovf;
                            acc_ovf <= acc_ovf | alu_ovf;
                        end
                        OP_NOT, OP_AND, OP_OR: acc <= alu_f;
                        OP_LOAD:               acc <= operand;
                        OP_CLRF:               acc_ovf <= 1'b0;
                        default:               rsp_err <= 1'b1;
                    endcase

                    if (cnt == 4'd0) begin
                        alu_sel   <= SEL_ADD;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_RESP: begin
                    // The command slot only reopens on the following edge,
                    // so back-to-back commands are at least 3 cycles apart.
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    alu_sel   <= SEL_ADD;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eightbit_palu_ctrl.sv
// Directed bench for eightbit_palu_ctrl with eightbit_palu as its ALU.
module tb_eightbit_palu_ctrl;
    import eightbit_palu_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] alu_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_f;
    logic       alu_ovf;
    logic       acc_ovf;
    state_t     dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] trace[$];
    logic [1:0] sel_exec;
    int         exec_n;
    logic       got_rsp;

    eightbit_palu_ctrl_if bus ();

    eightbit_palu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_ovf   (alu_ovf),
        .acc_ovf   (acc_ovf),
        .dbg_state (dbg_state)
    );

    eightbit_palu u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .sel (alu_sel),
        .f   (alu_f),
        .ovf (alu_ovf)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Presents one command at a negedge, lets it be accepted on the next
    // posedge and then watches negedges until rsp_valid (bounded). alu_a is
    // traced every negedge so the accumulator after each iteration shows up.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] data,
                          input logic [3:0] rep);
        trace.delete();
        exec_n  = 0;
        got_rsp = 1'b0;
        sel_exec = 2'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_rep   = rep;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            trace.push_back(alu_a);
            if (bus.rsp_valid) begin
                got_rsp = 1'b1;
                break;
            end
            if (dbg_state == ST_EXEC) begin
                if (exec_n == 0) sel_exec = alu_sel;
                exec_n++;
            end
        end
        check("rsp_timeout", {31'd0, got_rsp}, 32'd1);
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] data,
                              input logic ovf, input logic err,
                              input int n_exec, input logic [1:0] sel);
        check({tag, "_data"}, {24'd0, bus.rsp_data}, {24'd0, data});
        check({tag, "_ovf"},  {31'd0, bus.rsp_ovf},  {31'd0, ovf});
        check({tag, "_err"},  {31'd0, bus.rsp_err},  {31'd0, err});
        check({tag, "_exec"}, exec_n, n_exec);
        check({tag, "_sel"},  {30'd0, sel_exec},     {30'd0, sel});
        finish_rsp();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 8'h00;
        bus.cmd_rep   = 4'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset then idle
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_acc",       {24'd0, alu_a},         32'h00);
        check("rst_operand",   {24'd0, alu_b},         32'h00);
        check("rst_alu_sel",   {30'd0, alu_sel},       32'd0);
        check("rst_acc_ovf",   {31'd0, acc_ovf},       32'd0);
        check("rst_state",     {30'd0, dbg_state},     {30'd0, ST_IDLE});

        // LOAD 0xAB, ADD 0x55 wraps to 0x00 with carry, CLRF clears sticky
        do_cmd(OP_LOAD, 8'hAB, 4'd0);
        expect_rsp("load_ab", 8'hAB, 1'b0, 1'b0, 1, 2'd0);
        do_cmd(OP_ADD, 8'h55, 4'd0);
        check("add55_acc_ovf", {31'd0, acc_ovf}, 32'd1);
        expect_rsp("add55", 8'h00, 1'b1, 1'b0, 1, 2'd0);
        do_cmd(OP_CLRF, 8'hEE, 4'd9);
        check("clrf_acc_ovf", {31'd0, acc_ovf}, 32'd0);
        expect_rsp("clrf", 8'h00, 1'b0, 1'b0, 1, 2'd0);

        // 0xFF + 0x01 wrap-around
        do_cmd(OP_LOAD, 8'hFF, 4'd0);
        expect_rsp("load_ff", 8'hFF, 1'b0, 1'b0, 1, 2'd0);
        do_cmd(OP_ADD, 8'h01, 4'd0);
        check("wrap_acc_ovf", {31'd0, acc_ovf}, 32'd1);
        expect_rsp("wrap", 8'h00, 1'b1, 1'b0, 1, 2'd0);
        do_cmd(OP_CLRF, 8'h00, 4'd0);
        expect_rsp("clrf2", 8'h00, 1'b0, 1'b0, 1, 2'd0);

        // ADD 0x40 repeated 4 times from 0x00
        do_cmd(OP_LOAD, 8'h00, 4'd0);
        expect_rsp("load_00", 8'h00, 1'b0, 1'b0, 1, 2'd0);
        do_cmd(OP_ADD, 8'h40, 4'd3);
        check("rep_trace_len", trace.size(), 5);
        if (trace.size() == 5) begin
            check("rep_acc1", {24'd0, trace[1]}, 32'h40);
            check("rep_acc2", {24'd0, trace[2]}, 32'h80);
            check("rep_acc3", {24'd0, trace[3]}, 32'hC0);
            check("rep_acc4", {24'd0, trace[4]}, 32'h00);
        end
        check("rep_acc_ovf", {31'd0, acc_ovf}, 32'd1);
        expect_rsp("rep", 8'h00, 1'b1, 1'b0, 4, 2'd0);

        // Logic ops; sticky carry (still 1) must survive them
        do_cmd(OP_LOAD, 8'h55, 4'd7);
        expect_rsp("load_55", 8'h55, 1'b0, 1'b0, 1, 2'd0);
        do_cmd(OP_NOT, 8'hAA, 4'd5);
        expect_rsp("not_aa", 8'h55, 1'b0, 1'b0, 1, 2'd1);
        do_cmd(OP_AND, 8'h0F, 4'd0);
        expect_rsp("and_0f", 8'h05, 1'b0, 1'b0, 1, 2'd2);
        do_cmd(OP_OR, 8'hF0, 4'd2);
        check("or_acc_ovf", {31'd0, acc_ovf}, 32'd1);
        expect_rsp("or_f0", 8'hF5, 1'b0, 1'b0, 1, 2'd3);
        @(negedge clk);
        check("idle_alu_sel", {30'd0, alu_sel}, 32'd0);

        // Backpressure: response held for 5 cycles while a command waits
        do_cmd(OP_LOAD, 8'h3C, 4'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_rsp_data",  {24'd0, bus.rsp_data},  32'h3C);
            check("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        // The waiting command must not have been taken on the release edge
        check("release_state",     {30'd0, dbg_state},     {30'd0, ST_IDLE});
        check("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("release_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b0;

        // Illegal opcode 7
        do_cmd(3'd7, 8'h12, 4'd4);
        check("ill_acc_ovf", {31'd0, acc_ovf}, 32'd1);
        expect_rsp("ill", 8'h3C, 1'b0, 1'b1, 1, 2'd0);

        // Reset during the second iteration of ADD rep=5
        do_cmd(OP_LOAD, 8'h77, 4'd0);
        expect_rsp("load_77", 8'h77, 1'b0, 1'b0, 1, 2'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_data  = 8'h01;
        bus.cmd_rep   = 4'd5;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_state1", {30'd0, dbg_state}, {30'd0, ST_EXEC});
        @(negedge clk);
        check("mid_acc2", {24'd0, alu_a}, 32'h78);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mrst_state",     {30'd0, dbg_state},     {30'd0, ST_IDLE});
        check("mrst_acc",       {24'd0, alu_a},         32'h00);
        check("mrst_operand",   {24'd0, alu_b},         32'h00);
        check("mrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("mrst_acc_ovf",   {31'd0, acc_ovf},       32'd0);
        got_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) got_rsp = 1'b1;
        end
        check("mrst_no_rsp", {31'd0, got_rsp}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
